// File: rtl/uart_bfm.sv
// 8N1 UART transceiver used as the bench-side serial peer; TX and RX run independently.
// Optional macro UART_BFM_FRAME_CHECK_EN enables stop-bit checking and rx_frame_err.
module uart_bfm #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_finish,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_finish,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  // ---------------- TX ----------------
  st_t           tx_st, tx_st_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic          tx_start_q;
  logic          ser_tx_d, tx_busy_d, tx_finish_d, tx_clear_d;
  logic          tx_fire;

  assign tx_fire = tx_start & ~tx_start_q & (tx_st == S_IDLE);

  always_comb begin
    tx_st_d     = tx_st;
    tx_cnt_d    = tx_cnt;
    tx_bit_d    = tx_bit;
    tx_sh_d     = tx_sh;
    ser_tx_d    = ser_tx;
    tx_busy_d   = tx_busy;
    tx_finish_d = tx_finish;
    case (tx_st)
      S_IDLE: if (tx_fire) begin
        tx_st_d     = S_START;
        tx_cnt_d    = '0;
        tx_sh_d     = tx_data;
        ser_tx_d    = 1'b0;
        tx_busy_d   = 1'b1;
        tx_finish_d = 1'b0;
      end
      S_START: if (tx_cnt == BIT_END) begin
        tx_st_d  = S_DATA;
        tx_cnt_d = '0;
        tx_bit_d = 3'd0;
        ser_tx_d = tx_sh[0];
      end else tx_cnt_d = tx_cnt + 1'b1;
      S_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit == 3'd7) begin
          tx_st_d  = S_STOP;
          ser_tx_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit + 3'd1;
          tx_sh_d  = {1'b0, tx_sh[7:1]};
          ser_tx_d = tx_sh[1];
        end
      end else tx_cnt_d = tx_cnt + 1'b1;
      S_STOP: if (tx_cnt == BIT_END) begin
        tx_st_d     = S_IDLE;
        tx_busy_d   = 1'b0;
        tx_finish_d = 1'b1;
      end else tx_cnt_d = tx_cnt + 1'b1;
      default: tx_st_d = S_IDLE;
    endcase
    // Tracks the finish flag as it will be after this edge, so the request drops with a restart.
    tx_clear_d = tx_finish_d & tx_start;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_st        <= S_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= 3'd0;
      tx_sh        <= 8'h00;
      tx_start_q   <= 1'b0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_finish    <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      tx_st        <= tx_st_d;
      tx_cnt       <= tx_cnt_d;
      tx_bit       <= tx_bit_d;
      tx_sh        <= tx_sh_d;
      tx_start_q   <= tx_start;
      ser_tx       <= ser_tx_d;
      tx_busy      <= tx_busy_d;
      tx_finish    <= tx_finish_d;
      tx_clear_req <= tx_clear_d;
    end
  end

  // ---------------- RX ----------------
  st_t           rx_st, rx_st_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic [7:0]    rx_data_d;
  logic          rx_finish_d;
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
`ifdef UART_BFM_FRAME_CHECK_EN
  logic          rx_err_d;
`endif

  // rx_prev must be high for a fall, so after a bad stop the line has to return high first.
  assign rx_fall = rx_prev & ~rx_s2;

  always_comb begin
    rx_st_d     = rx_st;
    rx_cnt_d    = rx_cnt;
    rx_bit_d    = rx_bit;
    rx_sh_d     = rx_sh;
    rx_data_d   = rx_data;
    rx_finish_d = 1'b0;
`ifdef UART_BFM_FRAME_CHECK_EN
    rx_err_d    = 1'b0;
`endif
    case (rx_st)
      S_IDLE: if (rx_fall) begin
        rx_st_d  = S_START;
        rx_cnt_d = '0;
      end
      S_START: if (rx_cnt == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = 3'd0;
        rx_st_d  = rx_s2 ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt + 1'b1;
      S_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_st_d = S_STOP;
        else                rx_bit_d = rx_bit + 3'd1;
      end else rx_cnt_d = rx_cnt + 1'b1;
      S_STOP: if (rx_cnt == BIT_END) begin
        rx_st_d = S_IDLE;
`ifdef UART_BFM_FRAME_CHECK_EN
        if (!rx_s2) rx_err_d = 1'b1;
        else begin
          rx_data_d   = rx_sh;
          rx_finish_d = 1'b1;
        end
`else
        rx_data_d   = rx_sh;
        rx_finish_d = 1'b1;
`endif
      end else rx_cnt_d = rx_cnt + 1'b1;
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_sh     <= 8'h00;
      rx_data   <= 8'h00;
      rx_finish <= 1'b0;
    end else begin
      rx_s1     <= ser_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_st     <= rx_st_d;
      rx_cnt    <= rx_cnt_d;
      rx_bit    <= rx_bit_d;
      rx_sh     <= rx_sh_d;
      rx_data   <= rx_data_d;
      rx_finish <= rx_finish_d;
    end
  end

`ifdef UART_BFM_FRAME_CHECK_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_frame_err <= 1'b0;
    else         rx_frame_err <= rx_err_d;
  end
`else
  assign rx_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bfm.sv
// Self-checking bench for uart_bfm at CLKS_PER_BIT=16: TX vector table, RX scoreboard, corner cases.
module tb_uart_bfm;
  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       resetb, ser_rx, ser_tx, tx_start;
  logic [7:0] tx_data, rx_data;
  logic       tx_busy, tx_finish, tx_clear_req, rx_finish, rx_frame_err;

  uart_bfm #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .resetb(resetb), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_finish(tx_finish),
    .tx_clear_req(tx_clear_req), .rx_data(rx_data), .rx_finish(rx_finish),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  int rx_pulses = 0, err_pulses = 0;
  logic [7:0] rx_q[$];

  typedef struct { logic [7:0] data; logic [9:0] wave; } txv_t;
  txv_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Line level during bit-time i of a frame: start 0, data LSB first, stop 1.
  function automatic logic [9:0] tx_ref(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Scoreboard: every rx_finish pulse must match the oldest expected byte.
  always @(negedge clock) if (resetb) begin
    if (rx_finish) begin
      rx_pulses++;
      chk("rx_expected_pending", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) chk("rx_byte", rx_data, rx_q.pop_front());
    end
    if (rx_frame_err) err_pulses++;
  end

  task automatic tx_frame(input logic [7:0] d, input logic [9:0] w, input bit drop);
    int bad = 0;
    logic [9:0] seen = '0;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    chk("tx_busy_rise", tx_busy, 1);
    chk("tx_finish_clr", tx_finish, 0);
    for (int t = 0; t < 10 * CPB; t++) begin
      if (t > 0) @(negedge clock);
      if (ser_tx !== w[t / CPB] || tx_busy !== 1'b1) bad++;
      if (t % CPB == CPB / 2) seen[t / CPB] = ser_tx;
    end
    chk("tx_bits", seen, w);
    chk("tx_cycle_errs", bad, 0);
    @(negedge clock);
    chk("tx_end_busy", tx_busy, 0);
    chk("tx_end_finish", tx_finish, 1);
    if (drop) tx_start = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stopv);
    logic [9:0] f = {stopv, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (CPB) @(negedge clock);
    end
    ser_rx = 1'b1;
  endtask

  task automatic rand_tx(input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      tx_frame(d, tx_ref(d), 1'b1);
      repeat ($urandom_range(1, 4)) @(negedge clock);
    end
  endtask

  task automatic rand_rx(input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      rx_q.push_back(d);
      rx_send(d, 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h0F, 10'b1000011110};
    tbl[1] = '{8'h23, 10'b1001000110};
    tbl[2] = '{8'h00, 10'b1000000000};
    tbl[3] = '{8'hFF, 10'b1111111110};
    tbl[4] = '{8'hA5, 10'b1101001010};

    resetb = 1'b0; ser_rx = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_finish", tx_finish, 0);
    chk("rst_clear_req", tx_clear_req, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_finish", rx_finish, 0);
    chk("rst_frame_err", rx_frame_err, 0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);

    // 0x0F with tx_start held high: no retrigger, clear request raised.
    tx_frame(tbl[0].data, tbl[0].wave, 1'b0);
    repeat (20) @(negedge clock);
    chk("hold_ser_tx", ser_tx, 1);
    chk("hold_busy", tx_busy, 0);
    chk("hold_clear_req", tx_clear_req, 1);
    tx_start = 1'b0;
    repeat (2) @(negedge clock);
    chk("drop_clear_req", tx_clear_req, 0);
    chk("drop_finish", tx_finish, 1);
    for (int i = 1; i < 5; i++) begin
      tx_frame(tbl[i].data, tbl[i].wave, 1'b1);
      repeat (2) @(negedge clock);
    end

    // Single and back-to-back RX frames.
    rx_q.push_back(8'hA5);
    rx_send(8'hA5, 1'b1);
    repeat (10) @(negedge clock);
    chk("rx_a5", rx_data, 8'hA5);
    rx_q.push_back(8'h3C);
    rx_q.push_back(8'h81);
    rx_send(8'h3C, 1'b1);
    rx_send(8'h81, 1'b1);
    repeat (10) @(negedge clock);
    chk("rx_b2b_last", rx_data, 8'h81);
    chk("rx_pulse_count", rx_pulses, 3);

    // Short low glitch must be rejected.
    ser_rx = 1'b0;
    repeat (5) @(negedge clock);
    ser_rx = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_rx_data", rx_data, 8'h81);
    chk("glitch_pulse_count", rx_pulses, 3);
    rx_q.push_back(8'h5A);
    rx_send(8'h5A, 1'b1);
    repeat (10) @(negedge clock);
    chk("after_glitch", rx_data, 8'h5A);

    // Bad stop bit.
`ifdef UART_BFM_FRAME_CHECK_EN
    rx_send(8'h66, 1'b0);
    repeat (20) @(negedge clock);
    chk("ferr_pulses", err_pulses, 1);
    chk("ferr_rx_data", rx_data, 8'h5A);
`else
    rx_q.push_back(8'h66);
    rx_send(8'h66, 1'b0);
    repeat (20) @(negedge clock);
    chk("ferr_pulses", err_pulses, 0);
    chk("ferr_rx_data", rx_data, 8'h66);
`endif

    // TX and RX concurrently with random data.
    fork
      rand_tx(4);
      rand_rx(6);
    join
    repeat (20) @(negedge clock);
    chk("rx_queue_drained", rx_q.size(), 0);

    // Reset during data bit 3 aborts immediately.
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clock);
    repeat (4 * CPB + CPB / 2) @(negedge clock);
    chk("pre_rst_busy", tx_busy, 1);
    resetb   = 1'b0;
    tx_start = 1'b0;
    #1;
    chk("midrst_ser_tx", ser_tx, 1);
    chk("midrst_busy", tx_busy, 0);
    @(negedge clock);
    resetb = 1'b1;
    repeat (3) @(negedge clock);
    chk("postrst_idle", ser_tx, 1);
    tx_frame(8'h96, tx_ref(8'h96), 1'b1);
    repeat (5) @(negedge clock);
    chk("err_pulses_total", err_pulses,
`ifdef UART_BFM_FRAME_CHECK_EN
        1
`else
        0
`endif
    );

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
